// File: rtl/obi_mem_arbiter.sv
// obi_mem_arbiter: data-priority OBI arbiter for fetch and load/store sharing one memory port, with a fetch starvation guard
module obi_mem_arbiter #(
    parameter int WIDTH           = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_req_i,
    input  logic [WIDTH-1:0] instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [WIDTH-1:0] instr_rdata_o,
    input  logic             data_req_i,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [WIDTH-1:0] data_addr_i,
    input  logic [WIDTH-1:0] data_wdata_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    output logic [WIDTH-1:0] data_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [3:0]       mem_be_o,
    output logic [WIDTH-1:0] mem_addr_o,
    output logic [WIDTH-1:0] mem_wdata_o,
    input  logic             mem_gnt_i,
    input  logic             mem_rvalid_i,
    input  logic [WIDTH-1:0] mem_rdata_i,
    output logic             busy_o,
    output logic             owner_o
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t        state;
    logic          owner, lock_valid, lock_owner, win, win_req, hs;
    logic [SW-1:0] streak;
    always_comb begin
        win = lock_valid ? lock_owner : (instr_req_i && data_req_i) ? (streak != SW'(MAX_DATA_STREAK)) : data_req_i;
        win_req = win ? data_req_i : instr_req_i;
        mem_req_o = !rst && state == IDLE && win_req;
        busy_o = !rst && state == WAIT;
        hs = mem_req_o && mem_gnt_i;
        instr_gnt_o = hs && !win;
        data_gnt_o = hs && win;
        mem_we_o = mem_req_o && win && data_we_i;
        mem_be_o = !mem_req_o ? 4'h0 : win ? data_be_i : 4'hF;
        mem_addr_o = !mem_req_o ? '0 : win ? data_addr_i : instr_addr_i;
        mem_wdata_o = (mem_req_o && win) ? data_wdata_i : '0;
        instr_rvalid_o = busy_o && !owner && mem_rvalid_i;
        data_rvalid_o = busy_o && owner && mem_rvalid_i;
        instr_rdata_o = (busy_o && !owner) ? mem_rdata_i : '0;
        data_rdata_o = (busy_o && owner) ? mem_rdata_i : '0;
        owner_o = !rst && owner;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
            streak     <= '0;
        end else if (state == IDLE) begin
            if (mem_req_o && !mem_gnt_i) begin
                lock_valid <= 1'b1;
                lock_owner <= win;
            end
            if (hs) begin
                lock_valid <= 1'b0;
                owner      <= win;
                state      <= WAIT;
                streak     <= (win && instr_req_i) ? ((streak == SW'(MAX_DATA_STREAK)) ? streak : streak + 1'b1) : '0;
            end
        end else if (mem_rvalid_i) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// tb_obi_mem_arbiter: directed checks of priority, lock, starvation guard, latency and reset
module tb_obi_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req_i, data_req_i, data_we_i, mem_gnt_i, mem_rvalid_i;
    logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, mem_rdata_i;
    logic [3:0]  data_be_i;
    logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
    logic        mem_req_o, mem_we_o, busy_o, owner_o;
    logic [3:0]  mem_be_o;
    logic [31:0] instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        exp_d;

    obi_mem_arbiter #(.WIDTH(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; instr_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
        instr_addr_i = 32'h40; data_addr_i = 32'h80; data_wdata_i = 32'h11; mem_gnt_i = 1'b1;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_mem_req", 32'(mem_req_o), 0);
            chk("rst_instr_gnt", 32'(instr_gnt_o), 0);
            chk("rst_data_gnt", 32'(data_gnt_o), 0);
            chk("rst_rvalid", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
            chk("rst_rdata", instr_rdata_o | data_rdata_o, 0);
            chk("rst_busy_owner", {30'd0, busy_o, owner_o}, 0);
            tick();
        end
        rst = 1'b0; data_req_i = 1'b0; instr_addr_i = 32'h100; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("i_mem_req", 32'(mem_req_o), 1);
        chk("i_addr", mem_addr_o, 32'h100);
        chk("i_we", 32'(mem_we_o), 0);
        chk("i_be", 32'(mem_be_o), 32'hF);
        chk("i_gnt", 32'(instr_gnt_o), 1);
        chk("i_dgnt", 32'(data_gnt_o), 0);
        tick();
        instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
        @(negedge clk);
        chk("i_busy", 32'(busy_o), 1);
        chk("i_wait_req", 32'(mem_req_o), 0);
        chk("i_rvalid", 32'(instr_rvalid_o), 1);
        chk("i_rdata", instr_rdata_o, 32'h55);
        chk("i_no_drvalid", 32'(data_rvalid_o), 0);
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h200; data_req_i = 1'b1; data_we_i = 1'b1;
        data_addr_i = 32'h8000; data_wdata_i = 32'hDEADBEEF; data_be_i = 4'h3; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("s_dgnt", 32'(data_gnt_o), 1);
        chk("s_ignt", 32'(instr_gnt_o), 0);
        chk("s_we", 32'(mem_we_o), 1);
        chk("s_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("s_be", 32'(mem_be_o), 32'h3);
        chk("s_addr", mem_addr_o, 32'h8000);
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234;
        @(negedge clk);
        chk("s_drvalid", 32'(data_rvalid_o), 1);
        chk("s_drdata", data_rdata_o, 32'h1234);
        chk("s_irvalid", 32'(instr_rvalid_o), 0);
        chk("s_irdata", instr_rdata_o, 0);
        chk("s_owner", 32'(owner_o), 1);
        tick();
        // streak is now 1; a locked fetch must still beat the newly arriving data request
        instr_req_i = 1'b1; instr_addr_i = 32'h300; data_we_i = 1'b0; data_addr_i = 32'h9000;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("l_addr", mem_addr_o, 32'h300);
            chk("l_req", 32'(mem_req_o), 1);
            chk("l_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 0);
            tick();
            data_req_i = 1'b1;
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk("l_addr_gnt", mem_addr_o, 32'h300);
        chk("l_ignt", 32'(instr_gnt_o), 1);
        chk("l_dgnt", 32'(data_gnt_o), 0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE;
        @(negedge clk);
        chk("l_irvalid", 32'(instr_rvalid_o), 1);
        chk("l_wait_dgnt", 32'(data_gnt_o), 0);
        tick();
        for (int k = 0; k < 10; k++) begin
            exp_d = (k % 5) != 4;
            @(negedge clk);
            chk("st_dgnt", 32'(data_gnt_o), 32'(exp_d));
            chk("st_ignt", 32'(instr_gnt_o), 32'(!exp_d));
            chk("st_idle_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
            tick();
            @(negedge clk);
            chk("st_busy", 32'(busy_o), 1);
            chk("st_owner", 32'(owner_o), 32'(exp_d));
            chk("st_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, {30'd0, !exp_d, exp_d});
            tick();
        end
        data_req_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("lat_igrant", 32'(instr_gnt_o), 1);
        tick();
        data_req_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mem_rvalid_i = (c == 4);
            @(negedge clk);
            chk("lat_busy", 32'(busy_o), 1);
            chk("lat_gnts", {30'd0, instr_gnt_o, data_gnt_o}, 0);
            chk("lat_irvalid", 32'(instr_rvalid_o), 32'(c == 4));
            tick();
        end
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("lat_next_busy", 32'(busy_o), 0);
        chk("lat_next_dgnt", 32'(data_gnt_o), 1);
        tick();
        rst = 1'b1; mem_rvalid_i = 1'b1;
        @(negedge clk);
        chk("mr_rst_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
        chk("mr_rst_busy", 32'(busy_o), 0);
        tick();
        rst = 1'b0; instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("mr_busy0", 32'(busy_o), 0);
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hABCD;
        @(negedge clk);
        chk("mr_late_rv", {30'd0, instr_rvalid_o, data_rvalid_o}, 0);
        chk("mr_late_busy", 32'(busy_o), 0);
        chk("mr_late_rdata", instr_rdata_o | data_rdata_o, 0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
